// File: rtl/out_register_if.sv
// Capture-side bus bundle for out_register.
// Master drives the bus and handshake; slave is the capture FIFO.
interface out_register_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] B;
    logic             EnableOUT;
    logic             AckOUT;
    logic             ClrOVF;
    logic [WIDTH-1:0] DataOut;
    logic             ValidOUT;
    logic             Full;
    logic             Empty;
    logic [CW-1:0]    Count;
    logic             Overflow;

    modport master (
        output B, EnableOUT, AckOUT, ClrOVF,
        input  DataOut, ValidOUT, Full, Empty, Count, Overflow
    );

    modport slave (
        input  B, EnableOUT, AckOUT, ClrOVF,
        output DataOut, ValidOUT, Full, Empty, Count, Overflow
    );
endinterface

// File: rtl/out_register.sv
// Bus capture FIFO: samples B on EnableOUT, presents first-word-fall-through
// head with valid/ack handshake and a sticky overflow flag.
module out_register #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input logic CLK,
    input logic nRST,
    out_register_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    countNext;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             push;
    logic             pop;
    logic             drop;

    // A pop frees the slot a same-cycle push needs, so full+pop still pushes.
    assign pop  = !empty && bus.AckOUT;
    assign push = bus.EnableOUT && (!full || pop);
    assign drop = bus.EnableOUT && full && !pop;

    assign countNext = count + CW'(push) - CW'(pop);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wrPtr] <= bus.B;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= countNext;
            full  <= (countNext == CW'(DEPTH));
            empty <= (countNext == '0);
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.ClrOVF) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.DataOut  = empty ? '0 : mem[rdPtr];
    assign bus.ValidOUT = !empty;
    assign bus.Full     = full;
    assign bus.Empty    = empty;
    assign bus.Count    = count;
    assign bus.Overflow = overflow;
endmodule

// File: tb/tb_out_register.sv
// Directed bench for out_register.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_out_register;
    logic CLK;
    logic nRST;
    int   checks;
    int   failures;

    out_register_if #(.WIDTH(4), .DEPTH(4)) bus ();

    out_register #(.WIDTH(4), .DEPTH(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pushWord(input logic [3:0] w);
        bus.B         = w;
        bus.EnableOUT = 1'b1;
        bus.AckOUT    = 1'b0;
        step();
        bus.EnableOUT = 1'b0;
    endtask

    task automatic popExpect(input string tag, input int exp);
        check(tag, int'(bus.DataOut), exp);
        check({tag, "_v"}, int'(bus.ValidOUT), 1);
        bus.AckOUT = 1'b1;
        step();
        bus.AckOUT = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_data"}, int'(bus.DataOut), 0);
        check({tag, "_valid"}, int'(bus.ValidOUT), 0);
        check({tag, "_empty"}, int'(bus.Empty), 1);
        check({tag, "_full"}, int'(bus.Full), 0);
        check({tag, "_count"}, int'(bus.Count), 0);
    endtask

    initial begin
        int expNext;
        checks   = 0;
        failures = 0;

        nRST          = 1'b0;
        bus.B         = 4'hF;
        bus.EnableOUT = 1'b1;
        bus.AckOUT    = 1'b0;
        bus.ClrOVF    = 1'b0;
        step();
        step();
        checkIdle("rst");
        check("rst_ovf", int'(bus.Overflow), 0);

        bus.B = 4'h1;
        nRST  = 1'b1;
        step();
        bus.B = 4'h2;
        step();
        bus.B = 4'h3;
        step();
        bus.EnableOUT = 1'b0;
        check("ord_count", int'(bus.Count), 3);
        check("ord_head", int'(bus.DataOut), 1);
        bus.AckOUT = 1'b1;
        step();
        check("ord_d2", int'(bus.DataOut), 2);
        step();
        check("ord_d3", int'(bus.DataOut), 3);
        step();
        bus.AckOUT = 1'b0;
        checkIdle("ord_end");

        pushWord(4'hA);
        pushWord(4'hB);
        pushWord(4'hC);
        pushWord(4'hD);
        check("full_flag", int'(bus.Full), 1);
        check("full_count", int'(bus.Count), 4);
        check("full_ovf0", int'(bus.Overflow), 0);
        pushWord(4'hE);
        check("drop_ovf", int'(bus.Overflow), 1);
        check("drop_count", int'(bus.Count), 4);
        popExpect("drop_a", 4'hA);
        popExpect("drop_b", 4'hB);
        popExpect("drop_c", 4'hC);
        popExpect("drop_d", 4'hD);
        checkIdle("drop_end");

        bus.ClrOVF = 1'b1;
        step();
        bus.ClrOVF = 1'b0;
        check("clr_ovf", int'(bus.Overflow), 0);

        pushWord(4'hA);
        pushWord(4'hB);
        pushWord(4'hC);
        pushWord(4'hD);
        bus.B         = 4'h7;
        bus.EnableOUT = 1'b1;
        bus.AckOUT    = 1'b1;
        step();
        bus.EnableOUT = 1'b0;
        bus.AckOUT    = 1'b0;
        check("pp_count", int'(bus.Count), 4);
        check("pp_ovf", int'(bus.Overflow), 0);
        check("pp_full", int'(bus.Full), 1);
        popExpect("pp_b", 4'hB);
        popExpect("pp_c", 4'hC);
        popExpect("pp_d", 4'hD);
        popExpect("pp_7", 4'h7);
        checkIdle("pp_drained");

        bus.B         = 4'h7;
        bus.EnableOUT = 1'b1;
        bus.AckOUT    = 1'b1;
        step();
        bus.EnableOUT = 1'b0;
        bus.AckOUT    = 1'b0;
        check("pe_count", int'(bus.Count), 1);
        check("pe_data", int'(bus.DataOut), 7);
        popExpect("pe_pop", 4'h7);
        checkIdle("pe_end");

        pushWord(4'h1);
        pushWord(4'h2);
        pushWord(4'h3);
        pushWord(4'h4);
        pushWord(4'h5);
        check("cd_ovf1", int'(bus.Overflow), 1);
        bus.B         = 4'h6;
        bus.EnableOUT = 1'b1;
        bus.ClrOVF    = 1'b1;
        step();
        bus.EnableOUT = 1'b0;
        check("cd_setwins", int'(bus.Overflow), 1);
        step();
        bus.ClrOVF = 1'b0;
        check("cd_clr", int'(bus.Overflow), 0);
        check("cd_count", int'(bus.Count), 4);
        popExpect("cd_1", 4'h1);
        popExpect("cd_2", 4'h2);
        popExpect("cd_3", 4'h3);
        popExpect("cd_4", 4'h4);
        checkIdle("cd_end");

        expNext = 0;
        pushWord(4'h0);
        pushWord(4'h1);
        for (int i = 2; i < 10; i++) begin
            check($sformatf("wrap_h%0d", i), int'(bus.DataOut), expNext);
            bus.B         = 4'(i);
            bus.EnableOUT = 1'b1;
            bus.AckOUT    = 1'b1;
            step();
            expNext++;
            check($sformatf("wrap_c%0d", i), int'(bus.Count), 2);
        end
        bus.EnableOUT = 1'b0;
        bus.AckOUT    = 1'b0;
        popExpect("wrap_8", 8);
        popExpect("wrap_9", 9);
        checkIdle("wrap_end");

        pushWord(4'h5);
        pushWord(4'h6);
        check("ar_pre", int'(bus.Count), 2);
        #3;
        nRST = 1'b0;
        #1;
        checkIdle("ar_async");
        step();
        nRST = 1'b1;
        step();
        checkIdle("ar_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
